// File: rtl/mips_multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM states, ALU operation codes, instruction fields and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        ALU_WB,
        BRANCH,
        JUMP,
        JUMP_REG,
        HALT
    } state_t;

    // Coarse grouping of states as seen by the ALU decoder
    typedef enum logic [2:0] {
        CLS_FETCH,
        CLS_DECODE,
        CLS_EXEC_R,
        CLS_EXEC_I,
        CLS_MEM_ADDR,
        CLS_BRANCH,
        CLS_OTHER
    } alu_class_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] PC_ALU_RESULT = 2'd0;
    localparam logic [1:0] PC_ALU_OUT    = 2'd1;
    localparam logic [1:0] PC_JUMP       = 2'd2;
    localparam logic [1:0] PC_RS         = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;
    localparam logic [1:0] SRCA_RT    = 2'd3;

    localparam logic [2:0] SRCB_RT       = 3'd0;
    localparam logic [2:0] SRCB_FOUR     = 3'd1;
    localparam logic [2:0] SRCB_SIMM     = 3'd2;
    localparam logic [2:0] SRCB_ZIMM     = 3'd3;
    localparam logic [2:0] SRCB_SHAMT    = 3'd4;
    localparam logic [2:0] SRCB_SIMM_SH2 = 3'd5;

    function automatic alu_class_t class_of(input state_t s);
        case (s)
            FETCH:    return CLS_FETCH;
            DECODE:   return CLS_DECODE;
            EXEC_R:   return CLS_EXEC_R;
            EXEC_I:   return CLS_EXEC_I;
            MEM_ADDR: return CLS_MEM_ADDR;
            BRANCH:   return CLS_BRANCH;
            default:  return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle: instruction fields and flags in, strobes and selects out.
// The master side is the control unit, the slave side is the datapath/memory.
interface mips_multicycle_control_if;
    import mips_ctrl_pkg::*;

    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemAck;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic [1:0] ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       Active;

    modport master (
        input  Opcode, Funct, Zero, MemAck,
        output MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite, RegDst, MemToReg, Active
    );

    modport slave (
        output Opcode, Funct, Zero, MemAck,
        input  MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite, RegDst, MemToReg, Active
    );

endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// Combinational ALU decoder: picks the ALU operation and operand selects for
// the current state class, and flags R-type functs the machine does not support.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_class_t alu_class,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic       illegal_funct
);

    always_comb begin
        alu_control   = ALU_ADD;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RT;
        illegal_funct = 1'b0;
        case (alu_class)
            CLS_FETCH:  alu_src_b = SRCB_FOUR;
            CLS_DECODE: alu_src_b = SRCB_SIMM_SH2;
            CLS_EXEC_R: begin
                alu_src_a = SRCA_RS;
                case (funct)
                    FN_ADDU: alu_control = ALU_ADD;
                    FN_SUBU: alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_XOR:  alu_control = ALU_XOR;
                    FN_SLT:  alu_control = ALU_SLT;
                    FN_SLTU: alu_control = ALU_SLTU;
                    FN_SLL: begin
                        alu_control = ALU_SLL;
                        alu_src_a   = SRCA_SHAMT;
                    end
                    FN_SRL: begin
                        alu_control = ALU_SRL;
                        alu_src_a   = SRCA_SHAMT;
                    end
                    // SRA routes rt through port A and the shift amount through port B
                    FN_SRA: begin
                        alu_control = ALU_SRA;
                        alu_src_a   = SRCA_RT;
                        alu_src_b   = SRCB_SHAMT;
                    end
                    default: illegal_funct = 1'b1;
                endcase
            end
            CLS_EXEC_I: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_SIMM;
                case (opcode)
                    OP_SLTI:  alu_control = ALU_SLT;
                    OP_SLTIU: alu_control = ALU_SLTU;
                    OP_ANDI: begin
                        alu_control = ALU_AND;
                        alu_src_b   = SRCB_ZIMM;
                    end
                    OP_ORI: begin
                        alu_control = ALU_OR;
                        alu_src_b   = SRCB_ZIMM;
                    end
                    OP_XORI: begin
                        alu_control = ALU_XOR;
                        alu_src_b   = SRCB_ZIMM;
                    end
                    default: alu_control = ALU_ADD;
                endcase
            end
            CLS_MEM_ADDR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_SIMM;
            end
            CLS_BRANCH: begin
                alu_src_a   = SRCA_RS;
                alu_control = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes and selects through the control interface.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input logic                       clk,
    input logic                       rst_n,
    mips_multicycle_control_if.master bus
);

    state_t     state;
    state_t     next_state;
    logic       rd_dest;
    logic       illegal_funct;
    logic [3:0] alu_control;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;

    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       active;

    alu_decoder u_alu_decoder (
        .alu_class     (class_of(state)),
        .opcode        (bus.Opcode),
        .funct         (bus.Funct),
        .alu_control   (alu_control),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .illegal_funct (illegal_funct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Remembers whether the pending ALU writeback targets rd (R-type) or rt (I-type)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dest <= 1'b0;
        end else if (state == DECODE) begin
            rd_dest <= (bus.Opcode == OP_RTYPE);
        end
    end

    always_comb begin
        next_state = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU_RESULT;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        active     = 1'b1;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                if (bus.MemAck) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                case (bus.Opcode)
                    OP_RTYPE: next_state = (bus.Funct == FN_JR) ? JUMP_REG : EXEC_R;
                    OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI: next_state = EXEC_I;
                    OP_LW, OP_SW:             next_state = MEM_ADDR;
                    OP_BEQ, OP_BNE:           next_state = BRANCH;
                    OP_J:                     next_state = JUMP;
                    default:                  next_state = HALT;
                endcase
            end
            EXEC_R: next_state = illegal_funct ? HALT : ALU_WB;
            EXEC_I: next_state = ALU_WB;
            ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = rd_dest;
                next_state = FETCH;
            end
            MEM_ADDR: next_state = (bus.Opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.MemAck) begin
                    next_state = MEM_WB;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.MemAck) begin
                    next_state = FETCH;
                end
            end
            BRANCH: begin
                pc_src     = PC_ALU_OUT;
                pc_write   = (bus.Opcode == OP_BNE) ? !bus.Zero : bus.Zero;
                next_state = FETCH;
            end
            JUMP: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                next_state = FETCH;
            end
            JUMP_REG: begin
                pc_src     = PC_RS;
                pc_write   = 1'b1;
                next_state = FETCH;
            end
            HALT: active = 1'b0;
            default: next_state = HALT;
        endcase
    end

    // Strobes are gated by reset so a request in flight drops before the next edge
    assign bus.MemRead    = mem_read & rst_n;
    assign bus.MemWrite   = mem_write & rst_n;
    assign bus.IRWrite    = ir_write & rst_n;
    assign bus.PCWrite    = pc_write & rst_n;
    assign bus.RegWrite   = reg_write & rst_n;
    assign bus.IorD       = iord;
    assign bus.PCSrc      = pc_src;
    assign bus.RegDst     = reg_dst;
    assign bus.MemToReg   = mem_to_reg;
    assign bus.Active     = active;
    assign bus.ALUControl = alu_control;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle expected output
// vectors are queued as stimulus is driven and compared after the outputs settle.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] src_a;
        logic [2:0] src_b;
        logic [3:0] alu;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       active;
    } vec_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       ack;
        logic       zero;
        vec_t       exp;
    } stim_t;

    logic clk;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t sb[$];

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t v_base();
        vec_t v;
        v        = '0;
        v.alu    = 4'b0010;
        v.active = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_reset();
        vec_t v = v_base();
        v.src_b = 3'd1;
        return v;
    endfunction

    function automatic vec_t v_fetch(input logic ack);
        vec_t v = v_base();
        v.mem_read = 1'b1;
        v.src_b    = 3'd1;
        v.ir_write = ack;
        v.pc_write = ack;
        return v;
    endfunction

    function automatic vec_t v_decode();
        vec_t v = v_base();
        v.src_b = 3'd5;
        return v;
    endfunction

    function automatic vec_t v_exec(input logic [3:0] alu, input logic [1:0] a, input logic [2:0] b);
        vec_t v = v_base();
        v.alu   = alu;
        v.src_a = a;
        v.src_b = b;
        return v;
    endfunction

    function automatic vec_t v_alu_wb(input logic dst);
        vec_t v = v_base();
        v.reg_write = 1'b1;
        v.reg_dst   = dst;
        return v;
    endfunction

    function automatic vec_t v_mem_rd();
        vec_t v = v_base();
        v.mem_read = 1'b1;
        v.iord     = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_mem_wb();
        vec_t v = v_base();
        v.reg_write  = 1'b1;
        v.mem_to_reg = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_mem_wr();
        vec_t v = v_base();
        v.mem_write = 1'b1;
        v.iord      = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_branch(input logic pcw);
        vec_t v = v_exec(4'b0110, 2'd1, 3'd0);
        v.pc_src   = 2'd1;
        v.pc_write = pcw;
        return v;
    endfunction

    function automatic vec_t v_jump(input logic [1:0] src);
        vec_t v = v_base();
        v.pc_src   = src;
        v.pc_write = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_halt();
        vec_t v = v_base();
        v.active = 1'b0;
        return v;
    endfunction

    function automatic stim_t mk(input logic [5:0] op, input logic [5:0] fn, input logic ack,
                                 input logic zero, input vec_t exp);
        stim_t s;
        s.op   = op;
        s.fn   = fn;
        s.ack  = ack;
        s.zero = zero;
        s.exp  = exp;
        return s;
    endfunction

    function automatic vec_t observe();
        vec_t v;
        v.mem_read   = bus.MemRead;
        v.mem_write  = bus.MemWrite;
        v.iord       = bus.IorD;
        v.ir_write   = bus.IRWrite;
        v.pc_write   = bus.PCWrite;
        v.pc_src     = bus.PCSrc;
        v.src_a      = bus.ALUSrcA;
        v.src_b      = bus.ALUSrcB;
        v.alu        = bus.ALUControl;
        v.reg_write  = bus.RegWrite;
        v.reg_dst    = bus.RegDst;
        v.mem_to_reg = bus.MemToReg;
        v.active     = bus.Active;
        return v;
    endfunction

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        bus.Opcode = s.op;
        bus.Funct  = s.fn;
        bus.MemAck = s.ack;
        bus.Zero   = s.zero;
        sb.push_back(s.exp);
    endtask

    // ALU instruction: fetch, decode, execute, writeback with MemAck tied high
    function automatic void add_alu(ref stim_t st[$], input logic [5:0] op, input logic [5:0] fn,
                                    input vec_t exe, input logic dst);
        st.push_back(mk(op, fn, 1'b1, 1'b0, v_fetch(1'b1)));
        st.push_back(mk(op, fn, 1'b1, 1'b0, v_decode()));
        st.push_back(mk(op, fn, 1'b1, 1'b0, exe));
        st.push_back(mk(op, fn, 1'b1, 1'b0, v_alu_wb(dst)));
    endfunction

    task automatic test_reset();
        vec_t e, o;
        bus.MemAck = 1'b1;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sb.push_back(v_reset());
            #1;
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", i, o, e);
            end
        end
        @(negedge clk);
        rst_n      = 1'b1;
        bus.MemAck = 1'b0;
        sb.push_back(v_fetch(1'b0));
        #1;
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got %h expected %h", o, e);
        end
    endtask

    task automatic test_rtype();
        stim_t st[$];
        vec_t  e, o;
        add_alu(st, OP_RTYPE, FN_ADDU, v_exec(4'b0010, 2'd1, 3'd0), 1'b1);
        add_alu(st, OP_RTYPE, FN_SRA,  v_exec(4'b1000, 2'd3, 3'd4), 1'b1);
        add_alu(st, OP_RTYPE, FN_SLL,  v_exec(4'b0100, 2'd2, 3'd0), 1'b1);
        add_alu(st, OP_RTYPE, FN_SRL,  v_exec(4'b0101, 2'd2, 3'd0), 1'b1);
        add_alu(st, OP_RTYPE, FN_SUBU, v_exec(4'b0110, 2'd1, 3'd0), 1'b1);
        add_alu(st, OP_RTYPE, FN_SLTU, v_exec(4'b1001, 2'd1, 3'd0), 1'b1);
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #1;
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL rtype cycle %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_itype();
        stim_t st[$];
        vec_t  e, o;
        add_alu(st, OP_ADDIU, 6'h15, v_exec(4'b0010, 2'd1, 3'd2), 1'b0);
        add_alu(st, OP_SLTI,  6'h2A, v_exec(4'b0111, 2'd1, 3'd2), 1'b0);
        add_alu(st, OP_ORI,   6'h08, v_exec(4'b0001, 2'd1, 3'd3), 1'b0);
        add_alu(st, OP_XORI,  6'h00, v_exec(4'b0011, 2'd1, 3'd3), 1'b0);
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #1;
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL itype cycle %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_lw_wait();
        stim_t st[$];
        vec_t  e, o;
        for (int k = 0; k < 4; k++) st.push_back(mk(OP_LW, 6'h00, k == 3, 1'b0, v_fetch(k == 3)));
        st.push_back(mk(OP_LW, 6'h00, 1'b1, 1'b0, v_decode()));
        st.push_back(mk(OP_LW, 6'h00, 1'b1, 1'b0, v_exec(4'b0010, 2'd1, 3'd2)));
        for (int k = 0; k < 4; k++) st.push_back(mk(OP_LW, 6'h00, k == 3, 1'b0, v_mem_rd()));
        st.push_back(mk(OP_LW, 6'h00, 1'b1, 1'b0, v_mem_wb()));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #1;
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL lw_wait cycle %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        vec_t  e, o;
        st.push_back(mk(OP_SW, 6'h00, 1'b1, 1'b0, v_fetch(1'b1)));
        st.push_back(mk(OP_SW, 6'h00, 1'b1, 1'b0, v_decode()));
        st.push_back(mk(OP_SW, 6'h00, 1'b1, 1'b0, v_exec(4'b0010, 2'd1, 3'd2)));
        st.push_back(mk(OP_SW, 6'h00, 1'b1, 1'b0, v_mem_wr()));
        st.push_back(mk(OP_J, 6'h00, 1'b1, 1'b0, v_fetch(1'b1)));
        st.push_back(mk(OP_J, 6'h00, 1'b1, 1'b0, v_decode()));
        st.push_back(mk(OP_J, 6'h00, 1'b1, 1'b0, v_jump(2'd2)));
        st.push_back(mk(OP_RTYPE, FN_JR, 1'b1, 1'b0, v_fetch(1'b1)));
        st.push_back(mk(OP_RTYPE, FN_JR, 1'b1, 1'b0, v_decode()));
        st.push_back(mk(OP_RTYPE, FN_JR, 1'b1, 1'b0, v_jump(2'd3)));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #1;
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_branch();
        stim_t      st[$];
        vec_t       e, o;
        logic [5:0] ops [4]   = '{OP_BEQ, OP_BNE, OP_BNE, OP_BEQ};
        logic       zeros [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       taken [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            st.push_back(mk(ops[k], 6'h00, 1'b1, 1'b0, v_fetch(1'b1)));
            st.push_back(mk(ops[k], 6'h00, 1'b1, 1'b0, v_decode()));
            st.push_back(mk(ops[k], 6'h00, 1'b1, zeros[k], v_branch(taken[k])));
        end
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #1;
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL branch cycle %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        stim_t st[$];
        vec_t  e, o;
        st.push_back(mk(OP_SW, 6'h00, 1'b1, 1'b0, v_fetch(1'b1)));
        st.push_back(mk(OP_SW, 6'h00, 1'b1, 1'b0, v_decode()));
        st.push_back(mk(OP_SW, 6'h00, 1'b1, 1'b0, v_exec(4'b0010, 2'd1, 3'd2)));
        st.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, v_mem_wr()));
        st.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, v_mem_wr()));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #1;
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL mid_write cycle %0d: got %h expected %h", i, o, e);
            end
        end
        #2 rst_n = 1'b0;
        sb.push_back(v_reset());
        #1;
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL mid_write_reset: got %h expected %h", o, e);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        bus.MemAck = 1'b0;
        sb.push_back(v_fetch(1'b0));
        #1;
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL mid_write_release: got %h expected %h", o, e);
        end
    endtask

    task automatic test_halt();
        stim_t st[$];
        vec_t  e, o;
        st.push_back(mk(6'h3F, 6'h00, 1'b1, 1'b0, v_fetch(1'b1)));
        st.push_back(mk(6'h3F, 6'h00, 1'b1, 1'b0, v_decode()));
        for (int k = 0; k < 20; k++) begin
            st.push_back(mk(6'h3F, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), v_halt()));
        end
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #1;
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL halt cycle %0d: got %h expected %h", i, o, e);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        sb.push_back(v_reset());
        #1;
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL halt_reset: got %h expected %h", o, e);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        bus.MemAck = 1'b0;
        sb.push_back(v_fetch(1'b0));
        #1;
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL halt_release: got %h expected %h", o, e);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        bus.Opcode = 6'h00;
        bus.Funct  = 6'h00;
        bus.Zero   = 1'b0;
        bus.MemAck = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_lw_wait();
        test_back_to_back();
        test_branch();
        test_reset_mid_write();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
